instr_encoder: RTL and testbench

Assembles MIPS instructions from a mnemonic code plus operand fields into 32-bit instruction words, buffers them, and streams them out with a word-aligned write address for loading instruction memory. It sits in the debug/stimulus path as the counterpart of the instruction display decoder: that decoder turns `Op`/`Func` into mnemonics, and this block turns mnemonics into `Op`/`Func`-bearing words that the same decoder must name back.

---
 rtl/instr_encoder_if.sv | 29 ++
 rtl/instr_encoder.sv | 138 +++++++++++++
 tb/tb_instr_encoder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/stream bundle between a stimulus source and instr_encoder
// slave is the encoder's view, master is the driver/consumer view.
interface instr_encoder_if;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_mnem;
  logic [4:0]  s_rs;
  logic [4:0]  s_rt;
  logic [4:0]  s_rd;
  logic [4:0]  s_shamt;
  logic [15:0] s_imm;
  logic [25:0] s_target;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_instr;
  logic [31:0] m_addr;
  logic [15:0] emit_cnt;
  logic        err;

  modport slave (
    input  s_valid, s_mnem, s_rs, s_rt, s_rd, s_shamt, s_imm, s_target, m_ready,
    output s_ready, m_valid, m_instr, m_addr, emit_cnt, err
  );

  modport master (
    output s_valid, s_mnem, s_rs, s_rt, s_rd, s_shamt, s_imm, s_target, m_ready,
    input  s_ready, m_valid, m_instr, m_addr, emit_cnt, err
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS mnemonic-to-word encoder with E register, output FIFO and address stream
// Optional INSTR_ENC_CHECK_EN: drop illegal codes at E and raise sticky err instead of emitting NOP.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  instr_encoder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          r_e_valid;
  logic [31:0]   r_e_word;
  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_addr;
  logic [15:0]   r_emit_cnt;

  logic [31:0]   w_enc_word;
  logic [CW-1:0] w_occ;
  logic          w_accept;
  logic          w_e_adv;
  logic          w_push;
  logic          w_pop;

  // Unlisted codes fall through to the all-zero word (NOP).
  always_comb begin
    w_enc_word = 32'd0;
    case (bus.s_mnem)
      5'd0:  w_enc_word = {6'd0, 5'd0, bus.s_rt, bus.s_rd, bus.s_shamt, 6'd0};
      5'd1:  w_enc_word = {6'd0, 5'd0, bus.s_rt, bus.s_rd, bus.s_shamt, 6'd3};
      5'd2:  w_enc_word = {6'd0, 5'd0, bus.s_rt, bus.s_rd, bus.s_shamt, 6'd2};
      5'd3:  w_enc_word = {6'd0, bus.s_rs, bus.s_rt, bus.s_rd, 5'd0, 6'd32};
      5'd4:  w_enc_word = {6'd0, bus.s_rs, bus.s_rt, bus.s_rd, 5'd0, 6'd33};
      5'd5:  w_enc_word = {6'd0, bus.s_rs, bus.s_rt, bus.s_rd, 5'd0, 6'd34};
      5'd6:  w_enc_word = {6'd0, bus.s_rs, bus.s_rt, bus.s_rd, 5'd0, 6'd36};
      5'd7:  w_enc_word = {6'd0, bus.s_rs, bus.s_rt, bus.s_rd, 5'd0, 6'd37};
      5'd8:  w_enc_word = {6'd0, bus.s_rs, bus.s_rt, bus.s_rd, 5'd0, 6'd39};
      5'd9:  w_enc_word = {6'd0, bus.s_rs, bus.s_rt, bus.s_rd, 5'd0, 6'd42};
      5'd10: w_enc_word = {6'd0, bus.s_rs, bus.s_rt, bus.s_rd, 5'd0, 6'd43};
      5'd11: w_enc_word = {6'd0, bus.s_rs, 15'd0, 6'd8};
      5'd12: w_enc_word = {26'd0, 6'd12};
      5'd13: w_enc_word = {6'd2, bus.s_target};
      5'd14: w_enc_word = {6'd3, bus.s_target};
      5'd15: w_enc_word = {6'd4, bus.s_rs, bus.s_rt, bus.s_imm};
      5'd16: w_enc_word = {6'd5, bus.s_rs, bus.s_rt, bus.s_imm};
      5'd17: w_enc_word = {6'd8, bus.s_rs, bus.s_rt, bus.s_imm};
      5'd18: w_enc_word = {6'd9, bus.s_rs, bus.s_rt, bus.s_imm};
      5'd19: w_enc_word = {6'd10, bus.s_rs, bus.s_rt, bus.s_imm};
      5'd20: w_enc_word = {6'd12, bus.s_rs, bus.s_rt, bus.s_imm};
      5'd21: w_enc_word = {6'd13, bus.s_rs, bus.s_rt, bus.s_imm};
      5'd22: w_enc_word = {6'd35, bus.s_rs, bus.s_rt, bus.s_imm};
      5'd23: w_enc_word = {6'd43, bus.s_rs, bus.s_rt, bus.s_imm};
      default: w_enc_word = 32'd0;
    endcase
  end

  // Occupancy counts the E word so acceptance never overruns the FIFO.
  assign w_occ       = r_count + {{(CW-1){1'b0}}, r_e_valid};
  assign bus.s_ready = !clr && (w_occ < DEPTH_C);
  assign w_accept    = bus.s_valid && bus.s_ready;
  assign w_e_adv     = r_e_valid && (r_count != DEPTH_C);
  assign w_pop       = (r_count != '0) && bus.m_ready;

  assign bus.m_valid  = (r_count != '0);
  assign bus.m_instr  = (r_count != '0) ? r_mem[r_rd_ptr] : 32'd0;
  assign bus.m_addr   = r_addr;
  assign bus.emit_cnt = r_emit_cnt;

`ifdef INSTR_ENC_CHECK_EN
  logic r_e_illegal;
  logic r_err;
  logic w_enc_illegal;

  assign w_enc_illegal = (bus.s_mnem > 5'd23);
  assign w_push        = w_e_adv && !r_e_illegal;
  assign bus.err       = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_e_illegal <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_e_illegal <= w_enc_illegal;
      if (w_enc_illegal) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_push  = w_e_adv;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_e_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_e_valid  <= 1'b0;
      r_e_word   <= 32'd0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_addr     <= BASE_ADDR;
      r_emit_cnt <= 16'd0;
    end else begin
      if (w_accept) begin
        r_e_valid <= 1'b1;
        r_e_word  <= w_enc_word;
      end else if (w_e_adv) begin
        r_e_valid <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_addr     <= r_addr + 32'd4;
        r_emit_cnt <= r_emit_cnt + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
// Base address sits one word below 2^32 so the second emitted word exercises wraparound.
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_FFFC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl_addr = BASE;
  logic [15:0] mdl_cnt  = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tg);
    bus.s_mnem = mn; bus.s_rs = rs; bus.s_rt = rt; bus.s_rd = rd;
    bus.s_shamt = sh; bus.s_imm = imm; bus.s_target = tg;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.s_ready) begin
        tick(1);
        bus.s_valid = 1'b0;
        return;
      end
      tick(1);
    end
    check("send_timeout", {31'd0, bus.s_ready}, 32'd1);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                          input logic [25:0] tg, input logic [31:0] exp);
    exp_q.push_back(exp);
    send(mn, rs, rt, rd, sh, imm, tg);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      tick(1);
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every output handshake must match the next expected word and address.
  always @(negedge clk) begin
    if (rst_n && !clr && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {31'd0, bus.m_valid}, 32'd0);
      end else begin
        check("word", bus.m_instr, exp_q.pop_front());
        check("addr", bus.m_addr, mdl_addr);
        mdl_addr = mdl_addr + 32'd4;
        mdl_cnt  = mdl_cnt + 16'd1;
      end
    end
  end

  initial begin
    int idx;
    bit acc;
    bus.s_valid = 1'b0; bus.s_mnem = '0; bus.s_rs = '0; bus.s_rt = '0; bus.s_rd = '0;
    bus.s_shamt = '0; bus.s_imm = '0; bus.s_target = '0; bus.m_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;

    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_instr", bus.m_instr, 32'd0);
    check("rst_m_addr", bus.m_addr, BASE);
    check("rst_emit_cnt", {16'd0, bus.emit_cnt}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);

    bus.m_ready = 1'b1;
    send_exp(5'd17, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'd0, 32'h2022_0005);
    check("lat1_m_valid", {31'd0, bus.m_valid}, 32'd0);
    tick(1);
    check("lat2_m_valid", {31'd0, bus.m_valid}, 32'd1);
    check("lat2_m_instr", bus.m_instr, 32'h2022_0005);
    check("lat2_m_addr", bus.m_addr, BASE);
    send_exp(5'd3,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 26'd0,         32'h0022_1820);
    send_exp(5'd0,  5'd7,  5'd2,  5'd3,  5'd4, 16'h0000, 26'd0,         32'h0002_1900);
    send_exp(5'd1,  5'd7,  5'd2,  5'd3,  5'd4, 16'h0000, 26'd0,         32'h0002_1903);
    send_exp(5'd14, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h000_0010,  32'h0C00_0010);
    send_exp(5'd12, 5'd9,  5'd9,  5'd9,  5'd9, 16'hFFFF, 26'h3FF_FFFF,  32'h0000_000C);
    send_exp(5'd11, 5'd31, 5'd5,  5'd6,  5'd7, 16'h0000, 26'd0,         32'h03E0_0008);
    send_exp(5'd23, 5'd29, 5'd31, 5'd0,  5'd0, 16'h0004, 26'd0,         32'hAFBF_0004);
    send_exp(5'd22, 5'd29, 5'd31, 5'd0,  5'd0, 16'h0004, 26'd0,         32'h8FBF_0004);
    send_exp(5'd15, 5'd1,  5'd2,  5'd0,  5'd0, 16'hFFFF, 26'd0,         32'h1022_FFFF);
    send_exp(5'd5,  5'd1,  5'd2,  5'd3,  5'd5, 16'h0000, 26'd0,         32'h0022_1822);
    send_exp(5'd13, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h3FF_FFFF,  32'h0BFF_FFFF);
    send_exp(5'd21, 5'd0,  5'd1,  5'd0,  5'd0, 16'h1234, 26'd0,         32'h3401_1234);
    send_exp(5'd8,  5'd4,  5'd5,  5'd6,  5'd0, 16'h0000, 26'd0,         32'h0085_3027);
    send_exp(5'd10, 5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 26'd0,         32'h0022_182B);
    drain();
    check("emit_cnt_a", {16'd0, bus.emit_cnt}, {16'd0, mdl_cnt});

    // Flush with three words buffered and a request offered in the clr cycle.
    bus.m_ready = 1'b0;
    send_exp(5'd17, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0001, 26'd0, 32'h2021_0001);
    send_exp(5'd17, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0002, 26'd0, 32'h2021_0002);
    send_exp(5'd17, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0003, 26'd0, 32'h2021_0003);
    tick(2);
    check("pre_clr_m_valid", {31'd0, bus.m_valid}, 32'd1);
    clr = 1'b1;
    bus.s_mnem = 5'd21; bus.s_rs = 5'd0; bus.s_rt = 5'd1; bus.s_imm = 16'hBEEF;
    bus.s_valid = 1'b1;
    #1;
    check("clr_s_ready", {31'd0, bus.s_ready}, 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.s_valid = 1'b0;
    exp_q.delete();
    mdl_addr = BASE;
    mdl_cnt  = 16'd0;
    check("clr_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("clr_emit_cnt", {16'd0, bus.emit_cnt}, 32'd0);
    check("clr_m_addr", bus.m_addr, BASE);
    check("clr_m_instr", bus.m_instr, 32'd0);
    bus.m_ready = 1'b1;
    tick(5);
    check("post_clr_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("post_clr_s_ready", {31'd0, bus.s_ready}, 32'd1);

    // Backpressure: offer six requests while the consumer stalls.
    bus.m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) begin
        bus.s_mnem = 5'd18; bus.s_rs = 5'd0; bus.s_rt = 5'(idx + 1);
        bus.s_imm = 16'h0100 + 16'(idx);
        bus.s_valid = 1'b1;
      end else begin
        bus.s_valid = 1'b0;
      end
      acc = bus.s_valid && bus.s_ready;
      tick(1);
      if (acc) begin
        exp_q.push_back(32'h2400_0000 | (32'(idx + 1) << 16) | (32'h0100 + 32'(idx)));
        idx++;
      end
    end
    bus.s_valid = 1'b0;
    check("bp_accepted", 32'(idx), 32'd4);
    check("bp_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("bp_m_instr_hold", bus.m_instr, 32'h2401_0100);
    tick(2);
    check("bp_m_instr_stable", bus.m_instr, 32'h2401_0100);
    check("bp_m_addr_stable", bus.m_addr, BASE);
    bus.m_ready = 1'b1;
    drain();
    check("bp_emit_cnt", {16'd0, bus.emit_cnt}, 32'd4);
    check("bp_m_addr_end", bus.m_addr, BASE + 32'd16);

    // Illegal mnemonic 27.
`ifdef INSTR_ENC_CHECK_EN
    send(5'd27, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'd0);
    tick(3);
    check("ill_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("ill_err", {31'd0, bus.err}, 32'd1);
    check("ill_m_addr", bus.m_addr, BASE + 32'd16);
`else
    send_exp(5'd27, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'd0, 32'h0000_0000);
    drain();
    check("ill_err", {31'd0, bus.err}, 32'd0);
`endif
    send_exp(5'd9, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 32'h0022_182A);
    drain();
    check("final_emit_cnt", {16'd0, bus.emit_cnt}, {16'd0, mdl_cnt});
    check("final_m_addr", bus.m_addr, mdl_addr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
